key_event_arbiter: RTL

//  Collects single-cycle key press pulses from the debounced key front end,
//  one pending flag per key, and hands them one at a time to a single consumer
//  (menu FSM, UART reporter) over a valid/ready channel as a binary key code.

---
 rtl/key_pkg.sv | 11 +
 rtl/key_rr_picker.sv | 30 +++
 rtl/key_event_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key event arbiter.
// Code width is clamped to one bit so a single-key build still has a legal out_code.
package key_pkg;

    typedef enum logic {ARB_IDLE, ARB_OUT} arb_state_e;

    function automatic int code_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_rr_picker.sv
// Round-robin picker: first set request at or after (last+1) mod N, with wrap.
// Purely combinational; any=0 leaves grant at 0.
module key_rr_picker
    import key_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = code_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          any,
    output logic [LW-1:0] grant
);

    // Walking the rotated order keeps the lowest rotated offset as the winner.
    always_comb begin
        int idx;
        any   = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last) + 1 + i) % N;
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises per-key press pulses into key codes on a valid/ready channel; press to valid is 2 cycles.
// Consumer stall holds out_code; repeat presses on an already-pending key are dropped and counted.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int KEY_NUM = 4,
    parameter int DROP_W  = 8,
    parameter int CW      = code_w(KEY_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_en,
    input  logic               en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_code,
    output logic [KEY_NUM-1:0] pend,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int DROP_MAX = (1 << DROP_W) - 1;

    arb_state_e         state_q, state_d;
    logic [KEY_NUM-1:0] pend_q, pend_d, clr;
    logic [CW-1:0]      out_code_q, out_code_d;
    logic [CW-1:0]      last_q, last_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               any, load;
    logic [CW-1:0]      grant;

    key_rr_picker #(.N(KEY_NUM), .LW(CW)) u_picker (
        .req   (pend_q),
        .last  (last_q),
        .any   (any),
        .grant (grant)
    );

    // In OUT a new grant is only taken on the handshake edge.
    assign load = en && any && ((state_q == ARB_IDLE) || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (load) state_d = ARB_OUT;
            ARB_OUT:  if (out_ready && !load) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ARB_OUT);
    end

    // A fresh pulse overrides a same-cycle grant clear, so it is neither lost nor dropped.
    always_comb begin
        int n_drop;
        int sum;
        clr = '0;
        if (load) clr[grant] = 1'b1;
        pend_d = (pend_q & ~clr) | key_en;
        n_drop = 0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (key_en[i] && pend_q[i] && !clr[i]) n_drop++;
        end
        sum        = int'(drop_q) + n_drop;
        drop_d     = (sum > DROP_MAX) ? {DROP_W{1'b1}} : DROP_W'(sum);
        out_code_d = load ? grant : out_code_q;
        last_d     = load ? grant : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            out_code_q <= '0;
            last_q     <= CW'(KEY_NUM - 1);
            drop_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            out_code_q <= out_code_d;
            last_q     <= last_d;
            drop_q     <= drop_d;
        end
    end

    assign out_code = out_code_q;
    assign pend     = pend_q;
    assign drop_cnt = drop_q;

endmodule
